// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between fetch and mem stages.
// One transaction in flight; data wins by default, a starvation counter lets fetch through.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        flush_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [3:0]  d_be_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    output logic        d_gnt_o,
    output logic        d_rvalid_o,
    output logic [31:0] d_rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
    typedef enum logic {OWN_DATA, OWN_FETCH} owner_t;

    state_t          r_state, w_state_nxt;
    owner_t          r_owner;
    logic [CW-1:0]   r_starve_cnt;
    logic            r_drop;

    logic            w_contended;
    logic            w_win_f;
    logic            w_issue;
    logic            w_sel_f;
    logic            w_resp;
    logic            w_set_drop;

    always_comb begin
        w_state_nxt = r_state;
        w_contended = if_req_i & d_req_i;
        w_win_f     = if_req_i & (~d_req_i | (r_starve_cnt == LIMIT));
        w_issue     = 1'b0;
        w_sel_f     = (r_owner == OWN_FETCH);
        w_resp      = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_addr_o  = 32'h0;
        mem_wdata_o = 32'h0;

        case (r_state)
            S_IDLE: begin
                if (if_req_i | d_req_i) begin
                    w_issue     = 1'b1;
                    w_sel_f     = w_win_f;
                    mem_req_o   = 1'b1;
                    w_state_nxt = mem_gnt_i ? S_WAIT : S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_req_o = 1'b1;
                if (mem_gnt_i) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (mem_rvalid_i) begin
                    w_resp      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Outputs must read zero while reset is held, even with requests pending.
        if (!rstn_i) begin
            w_issue   = 1'b0;
            w_resp    = 1'b0;
            mem_req_o = 1'b0;
        end

        if (mem_req_o) begin
            if (w_sel_f) begin
                mem_be_o   = 4'hF;
                mem_addr_o = if_addr_i;
            end else begin
                mem_we_o    = d_we_i;
                mem_be_o    = d_be_i;
                mem_addr_o  = d_addr_i;
                mem_wdata_o = d_wdata_i;
            end
        end

        if_gnt_o    = mem_gnt_i & mem_req_o & w_sel_f;
        d_gnt_o     = mem_gnt_i & mem_req_o & ~w_sel_f;
        if_rvalid_o = w_resp & (r_owner == OWN_FETCH) & ~r_drop & ~flush_i;
        if_rdata_o  = if_rvalid_o ? mem_rdata_i : 32'h0;
        d_rvalid_o  = w_resp & (r_owner == OWN_DATA);
        d_rdata_o   = d_rvalid_o ? mem_rdata_i : 32'h0;

        w_set_drop  = flush_i & ((w_issue & w_win_f) |
                      ((r_state == S_ISSUE || r_state == S_WAIT) && r_owner == OWN_FETCH));
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state      <= S_IDLE;
            r_owner      <= OWN_DATA;
            r_starve_cnt <= '0;
            r_drop       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_issue) begin
                r_owner <= w_win_f ? OWN_FETCH : OWN_DATA;
                if (w_win_f)
                    r_starve_cnt <= '0;
                else if (w_contended && r_starve_cnt != LIMIT)
                    r_starve_cnt <= r_starve_cnt + 1'b1;
            end
            // A returning response consumes the drop flag, whichever owner it had.
            if (w_resp)
                r_drop <= 1'b0;
            else if (w_set_drop)
                r_drop <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requesters and memory model drive,
// a monitor pops expected grants/responses as the DUT presents them.
module tb_mem_port_arbiter;
    logic        clk_i = 1'b0, rstn_i = 1'b0, flush_i = 1'b0;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = 32'h0;
    logic        if_gnt_o, if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        d_req_i = 1'b0, d_we_i = 1'b0;
    logic [3:0]  d_be_i = 4'h0;
    logic [31:0] d_addr_i = 32'h0, d_wdata_i = 32'h0;
    logic        d_gnt_o, d_rvalid_o;
    logic [31:0] d_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_gnt_i = 1'b1, mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'h0;

    mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .flush_i(flush_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i), .d_addr_i(d_addr_i),
        .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed { logic f; logic we; logic [3:0] be; logic [31:0] addr; logic [31:0] wdata; } gnt_t;
    typedef struct packed { logic f; logic [31:0] data; } rsp_t;
    typedef struct packed { logic we; logic [3:0] be; logic [31:0] addr; logic [31:0] wdata; } dcmd_t;

    gnt_t        exp_gnt[$];
    rsp_t        exp_rsp[$];
    logic [31:0] fq[$];
    dcmd_t       dq[$];
    int vectors = 0, miscompares = 0;
    int lat = 2;
    bit f_busy = 1'b0, d_busy = 1'b0, pend = 1'b0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    task automatic exp_g(input logic f, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
        gnt_t g;
        g = '{f: f, we: we, be: be, addr: addr, wdata: wdata};
        exp_gnt.push_back(g);
    endtask

    task automatic exp_r(input logic f, input logic [31:0] data);
        rsp_t r;
        r = '{f: f, data: data};
        exp_rsp.push_back(r);
    endtask

    task automatic push_d(input logic we, input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wdata);
        dcmd_t c;
        c = '{we: we, be: be, addr: addr, wdata: wdata};
        dq.push_back(c);
    endtask

    // Memory contents: stores read back 0, 0x100 holds addi x1,x0,5, others tag the address.
    function automatic logic [31:0] model(input logic [31:0] a, input logic w);
        if (w) return 32'h0;
        if (a == 32'h100) return 32'h0050_0093;
        return a | 32'hCAFE_0000;
    endfunction

    task automatic outs_zero(input string tag);
        chk({tag, "_ctl"}, {64'd0, if_gnt_o, if_rvalid_o, d_gnt_o, d_rvalid_o, mem_req_o, mem_we_o, mem_be_o != 4'h0},
            72'd0);
        chk({tag, "_addr"}, {40'd0, mem_addr_o}, 72'd0);
        chk({tag, "_wdata"}, {40'd0, mem_wdata_o}, 72'd0);
        chk({tag, "_rdata"}, {8'd0, if_rdata_o, d_rdata_o}, 72'd0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((fq.size() != 0 || dq.size() != 0 || f_busy || d_busy || pend ||
                exp_gnt.size() != 0 || exp_rsp.size() != 0) && n < 500) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 500) fail_now("drain_timeout");
        repeat (3) @(negedge clk_i);
    endtask

    task automatic reset_pulse();
        @(negedge clk_i);
        rstn_i = 1'b0;
        @(negedge clk_i);
        rstn_i = 1'b1;
        @(negedge clk_i);
    endtask

    initial begin : mem_model
        logic        fire, w;
        logic [31:0] a, d;
        int          cnt;
        cnt = 0;
        d = 32'h0;
        forever begin
            @(negedge clk_i);
            fire = mem_req_o && mem_gnt_i;
            a = mem_addr_o;
            w = mem_we_o;
            @(posedge clk_i);
            #1;
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = 32'h0;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = d;
                    pend = 1'b0;
                end
            end
            if (fire) begin
                pend = 1'b1;
                cnt  = lat - 1;
                d    = model(a, w);
                if (cnt <= 0) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = d;
                    pend = 1'b0;
                end
            end
        end
    end

    initial begin : fetch_requester
        int n;
        @(posedge clk_i);
        #1;
        forever begin
            if (fq.size() > 0) begin
                f_busy = 1'b1;
                if_addr_i = fq.pop_front();
                if_req_i = 1'b1;
                n = 0;
                @(negedge clk_i);
                while (!if_gnt_o && n < 200) begin n++; @(negedge clk_i); end
                if (!if_gnt_o) fail_now("if_gnt_timeout");
                @(posedge clk_i);
                #1;
                if_req_i = 1'b0;
                if_addr_i = 32'h0;
                f_busy = 1'b0;
            end else begin
                @(posedge clk_i);
                #1;
            end
        end
    end

    initial begin : data_requester
        dcmd_t c;
        int    n;
        @(posedge clk_i);
        #1;
        forever begin
            if (dq.size() > 0) begin
                d_busy = 1'b1;
                c = dq.pop_front();
                d_req_i = 1'b1; d_we_i = c.we; d_be_i = c.be; d_addr_i = c.addr; d_wdata_i = c.wdata;
                n = 0;
                @(negedge clk_i);
                while (!d_gnt_o && n < 200) begin n++; @(negedge clk_i); end
                if (!d_gnt_o) fail_now("d_gnt_timeout");
                @(posedge clk_i);
                #1;
                d_req_i = 1'b0; d_we_i = 1'b0; d_be_i = 4'h0; d_addr_i = 32'h0; d_wdata_i = 32'h0;
                d_busy = 1'b0;
            end else begin
                @(posedge clk_i);
                #1;
            end
        end
    end

    initial begin : monitor
        gnt_t g, e;
        rsp_t r, er;
        forever begin
            @(negedge clk_i);
            if (mem_req_o && mem_gnt_i) begin
                chk("gnt_onehot", {71'd0, if_gnt_o ^ d_gnt_o}, 72'd1);
                g = '{f: if_gnt_o, we: mem_we_o, be: mem_be_o, addr: mem_addr_o, wdata: mem_wdata_o};
                if (exp_gnt.size() == 0) begin
                    fail_now("unexpected_gnt");
                    $display("  grant was %h", g);
                end else begin
                    e = exp_gnt.pop_front();
                    chk("gnt", {2'd0, g}, {2'd0, e});
                end
            end
            if (if_rvalid_o && d_rvalid_o) fail_now("both_rvalid");
            if (if_rvalid_o || d_rvalid_o) begin
                r = '{f: if_rvalid_o, data: if_rvalid_o ? if_rdata_o : d_rdata_o};
                if (exp_rsp.size() == 0) begin
                    fail_now("unexpected_rvalid");
                    $display("  response was %h", r);
                end else begin
                    er = exp_rsp.pop_front();
                    chk("rsp", {39'd0, r}, {39'd0, er});
                end
            end
        end
    end

    initial begin : stimulus
        int n;
        repeat (2) @(negedge clk_i);
        outs_zero("reset");
        rstn_i = 1'b1;

        // Fetch only, grant in the request cycle, response two cycles later.
        @(negedge clk_i);
        lat = 2;
        exp_g(1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
        exp_r(1'b1, 32'h0050_0093);
        fq.push_back(32'h100);
        drain();

        // Contention with a fresh counter: data first, then fetch.
        reset_pulse();
        exp_g(1'b0, 1'b0, 4'hF, 32'h200, 32'h0);
        exp_g(1'b1, 1'b0, 4'hF, 32'h104, 32'h0);
        exp_r(1'b0, 32'hCAFE_0200);
        exp_r(1'b1, 32'hCAFE_0104);
        push_d(1'b0, 4'hF, 32'h200, 32'h0);
        fq.push_back(32'h104);
        drain();

        // Starvation: continuous requests give D,D,D,D,F,D,D,D,D,F.
        reset_pulse();
        lat = 1;
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 4; j++) begin
                exp_g(1'b0, 1'b0, 4'hF, 32'h200 + 32'(16 * k + 4 * j), 32'h0);
                exp_r(1'b0, 32'hCAFE_0200 + 32'(16 * k + 4 * j));
                push_d(1'b0, 4'hF, 32'h200 + 32'(16 * k + 4 * j), 32'h0);
            end
            exp_g(1'b1, 1'b0, 4'hF, 32'h500 + 32'(4 * k), 32'h0);
            exp_r(1'b1, 32'hCAFE_0500 + 32'(4 * k));
            fq.push_back(32'h500 + 32'(4 * k));
        end
        drain();

        // Delayed grant on a store; fetch arrives while the store is stuck in ISSUE.
        lat = 2;
        mem_gnt_i = 1'b0;
        exp_g(1'b0, 1'b1, 4'b0011, 32'h600, 32'hDEAD_BEEF);
        exp_r(1'b0, 32'h0);
        push_d(1'b1, 4'b0011, 32'h600, 32'hDEAD_BEEF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("hold_store", {1'b0, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, if_gnt_o},
                {1'b0, 1'b1, 1'b1, 4'b0011, 32'h600, 32'hDEAD_BEEF, 1'b0});
            if (i == 0) begin
                exp_g(1'b1, 1'b0, 4'hF, 32'h108, 32'h0);
                exp_r(1'b1, 32'hCAFE_0108);
                fq.push_back(32'h108);
            end
        end
        @(posedge clk_i);
        #1;
        mem_gnt_i = 1'b1;
        drain();

        // Flush during WAIT drops the fetch response; the next fetch returns normally.
        lat = 3;
        exp_g(1'b1, 1'b0, 4'hF, 32'h300, 32'h0);
        fq.push_back(32'h300);
        n = 0;
        @(negedge clk_i);
        while (!if_gnt_o && n < 100) begin n++; @(negedge clk_i); end
        if (!if_gnt_o) fail_now("flush_gnt_timeout");
        @(posedge clk_i);
        #1;
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        drain();
        exp_g(1'b1, 1'b0, 4'hF, 32'h10C, 32'h0);
        exp_r(1'b1, 32'hCAFE_010C);
        fq.push_back(32'h10C);
        drain();

        // Reset during an outstanding load; the late response must be ignored.
        lat = 4;
        exp_g(1'b0, 1'b0, 4'hF, 32'h700, 32'h0);
        push_d(1'b0, 4'hF, 32'h700, 32'h0);
        n = 0;
        @(negedge clk_i);
        while (!d_gnt_o && n < 100) begin n++; @(negedge clk_i); end
        if (!d_gnt_o) fail_now("rst_gnt_timeout");
        @(posedge clk_i);
        #1;
        rstn_i = 1'b0;
        #1;
        outs_zero("rst_mid");
        @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
        n = 0;
        @(negedge clk_i);
        while (!mem_rvalid_i && n < 20) begin n++; @(negedge clk_i); end
        if (!mem_rvalid_i) fail_now("late_rvalid_missing");
        chk("late_rvalid", {39'd0, d_rvalid_o, d_rdata_o}, 72'd0);
        drain();
        lat = 2;
        exp_g(1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
        exp_r(1'b1, 32'h0050_0093);
        fq.push_back(32'h100);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
